// File: rtl/mux_arbiter8.sv
// Eight-input round-robin bus arbiter with a bounded hold time per owner.
// A registered grant/select pair steers one of eight data words onto the
// shared bus; the owner keeps the bus until it drops its request or has held
// it for HOLD consecutive cycles. Then the search resumes just past the
// previous winner.
module mux_arbiter8 #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [7:0] in4,
    input  logic [7:0] in5,
    input  logic [7:0] in6,
    input  logic [7:0] in7,
    input  logic [7:0] in8,
    output logic [7:0] o,
    output logic       valid,
    output logic [7:0] grant,
    output logic       x,
    output logic       y,
    output logic       z
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_CNT = 4'(HOLD);

    state_t     state;
    state_t     state_next;
    logic [7:0] grant_next;
    logic       valid_next;
    logic [2:0] sel;
    logic [2:0] sel_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [2:0] ptr;
    logic [2:0] ptr_next;

    logic [2:0] winner;
    logic       found;
    logic [2:0] search_idx;
    logic       owner_req;
    logic       release_bus;
    logic [7:0] bus_data;

    // Rotating priority search: the first requester at or after ptr wins.
    always_comb begin
        winner     = 3'd0;
        found      = 1'b0;
        search_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            search_idx = ptr + 3'(i);
            if (!found && req[search_idx]) begin
                winner = search_idx;
                found  = 1'b1;
            end
        end
    end

    // The owner gives up the bus when it withdraws or exhausts its hold budget.
    always_comb begin
        owner_req   = |(req & grant);
        release_bus = !owner_req || (cnt == HOLD_CNT);
    end

    // Next-state and next-output decisions for the IDLE/BUSY controller.
    always_comb begin
        state_next = state;
        grant_next = grant;
        valid_next = valid;
        sel_next   = sel;
        cnt_next   = cnt;
        ptr_next   = ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_next = BUSY;
                    grant_next = 8'(1) << winner;
                    valid_next = 1'b1;
                    sel_next   = winner;
                    cnt_next   = 4'd1;
                    ptr_next   = winner + 3'd1;
                end
            end
            BUSY: begin
                if (!release_bus) begin
                    cnt_next = cnt + 4'd1;
                end else if (found) begin
                    grant_next = 8'(1) << winner;
                    valid_next = 1'b1;
                    sel_next   = winner;
                    cnt_next   = 4'd1;
                    ptr_next   = winner + 3'd1;
                end else begin
                    state_next = IDLE;
                    grant_next = 8'h00;
                    valid_next = 1'b0;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 8'h00;
                valid_next = 1'b0;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Controller registers; the synchronous reset wins over any grant in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 8'h00;
            valid <= 1'b0;
            sel   <= 3'd0;
            cnt   <= 4'd0;
            ptr   <= 3'd0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            valid <= valid_next;
            sel   <= sel_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
        end
    end

    // Bus data selection follows the registered owner index.
    always_comb begin
        bus_data = 8'h00;
        unique case (sel)
            3'd0: bus_data = in1;
            3'd1: bus_data = in2;
            3'd2: bus_data = in3;
            3'd3: bus_data = in4;
            3'd4: bus_data = in5;
            3'd5: bus_data = in6;
            3'd6: bus_data = in7;
            3'd7: bus_data = in8;
            default: bus_data = 8'h00;
        endcase
    end

    // The bus is driven only while a grant is active.
    always_comb begin
        o = valid ? bus_data : 8'h00;
        x = sel[2];
        y = sel[1];
        z = sel[0];
    end

endmodule
